word_loader: RTL and testbench
==============================

WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, word-memory address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, character width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cs  input  1  start request, sampled only in IDLE or DONE.
REQ-006 SHALL have port in_valid  input  1  character stream valid.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  character; 0x00 = end of message, 0x20/0x0A = delimiter.
REQ-008 SHALL have port in_ready  output  1  character accepted when in_valid & in_ready.
REQ-009 SHALL have port mem_we  output  1  write strobe to the word sram.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-011 SHALL have port mem_din  output  DATA_WIDTH  write data.
REQ-012 SHALL have port word_count  output  ADDR_WIDTH  words stored this run.
REQ-013 SHALL have port overflow  output  1  sticky, characters dropped for lack of space.
REQ-014 SHALL have port done  output  1  load complete; memory holds zero-separated words plus terminating empty word.

Function
REQ-015 SHALL implement states IDLE, LOAD, TERM1, TERM2, DONE.
REQ-016 IDLE/DONE with cs=1 SHALL clear mem_addr, word_count, overflow, done and go to LOAD next cycle.
REQ-017 in_ready SHALL be 1 only in LOAD; all other states hold in_ready=0.
REQ-018 LOAD, accepted non-delimiter non-zero char, space available: mem_we=1, mem_din=char, mem_addr advances by 1 the cycle after the write.
REQ-019 LOAD, accepted delimiter with a word pending (>=1 char written since last 0): write 0x00, mem_addr+1, word_count+1.
REQ-020 Leading and consecutive delimiters SHALL be consumed without any write.
REQ-021 LOAD, accepted 0x00: go to TERM1 if a word is pending, else TERM2; no write that cycle.
REQ-022 TERM1 SHALL write 0x00 at mem_addr, increment mem_addr and word_count, go to TERM2.
REQ-023 TERM2 SHALL write 0x00 at mem_addr (end-of-list empty word) and go to DONE; mem_addr does not advance.
REQ-024 DONE SHALL hold done=1, mem_we=0, all counters stable, until cs.
REQ-025 Space available in LOAD means mem_addr <= DEPTH-3; otherwise any write-causing char SHALL be consumed and dropped, overflow set to 1.
REQ-026 After overflow, no LOAD writes until end of message; TERM1/TERM2 still fit at DEPTH-2/DEPTH-1.
REQ-027 mem_we SHALL be high exactly one cycle per write; mem_addr/mem_din valid the same cycle.
REQ-028 cs outside IDLE/DONE SHALL be ignored.
REQ-029 in_valid without acceptance (in_ready=0) SHALL have no effect.

Reset
REQ-030 rst_n low SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_din=0, word_count=0, overflow=0, done=0, immediately and asynchronously.
REQ-031 Reset mid-LOAD SHALL abandon the run with no further writes; memory contents are not cleared.

Configuration
REQ-032 Macro WORD_LOADER_LOWERCASE_EN defined: accepted chars 0x41-0x5A SHALL be written as char+0x20; undefined: chars written unchanged.

Verification
REQ-033 cs, stream "ab cd",0x00 -> writes a,b,0,c,d,0,0 at addr 0-6; word_count=2; done=1; overflow=0.
REQ-034 cs, stream "  ab  ",0x00 -> writes a,b,0,0 at addr 0-3; word_count=1.
REQ-035 cs, stream 0x00 only -> single write 0x00 at addr 0; word_count=0; done=1.
REQ-036 DEPTH=16, cs, 20 non-delimiter chars then 0x00 -> 14 chars at addr 0-13, 0 at 14 and 15, overflow=1, word_count=1.
REQ-037 Assert rst_n low after 3 chars in LOAD -> all outputs at reset values same cycle; new cs restarts at addr 0.
REQ-038 With WORD_LOADER_LOWERCASE_EN, stream "AbC",0x00 -> writes 0x61,0x62,0x63,0,0; without macro -> 0x41,0x62,0x43,0,0.

Source files
------------

// File: rtl/word_loader.sv
// ============================================================================
// word_loader : splits a delimited character stream into zero-terminated words
// in a word sram. Build option: WORD_LOADER_LOWERCASE_EN folds A-Z to a-z.
// Revision: 1.0
// ============================================================================
`default_nettype none

module word_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Highest address a LOAD write may use; the last two slots are kept for TERM1/TERM2.
  localparam logic [ADDR_WIDTH-1:0] c_LOAD_LIMIT = ADDR_WIDTH'(DEPTH - 3);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TERM1 = 3'd2,
    TERM2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_count;
  logic                    r_ovf;
  logic                    r_pending;

  logic                    w_accept;
  logic                    w_is_zero;
  logic                    w_is_delim;
  logic                    w_room;
  logic [DATA_WIDTH-1:0]   w_char;
  logic                    w_clear;
  logic                    w_addr_inc;
  logic                    w_cnt_inc;
  logic                    w_set_ovf;
  logic                    w_pend_set;
  logic                    w_pend_clr;

`ifdef WORD_LOADER_LOWERCASE_EN
  assign w_char = (in_data >= DATA_WIDTH'(8'h41) && in_data <= DATA_WIDTH'(8'h5A))
                ? in_data + DATA_WIDTH'(8'h20) : in_data;
`else
  assign w_char = in_data;
`endif

  assign in_ready   = (r_state == LOAD);
  assign done       = (r_state == DONE);
  assign mem_addr   = r_addr;
  assign word_count = r_count;
  assign overflow   = r_ovf;

  assign w_accept   = in_valid && in_ready;
  assign w_is_zero  = (in_data == '0);
  assign w_is_delim = (in_data == DATA_WIDTH'(8'h20)) || (in_data == DATA_WIDTH'(8'h0A));
  assign w_room     = !r_ovf && (r_addr <= c_LOAD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_din     = '0;
    w_clear     = 1'b0;
    w_addr_inc  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_ovf   = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (cs) begin
          w_clear     = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (w_accept) begin
          if (w_is_zero) begin
            w_state_nxt = r_pending ? TERM1 : TERM2;
          end else if (w_is_delim) begin
            if (r_pending) begin
              if (w_room) begin
                mem_we     = 1'b1;
                w_addr_inc = 1'b1;
                w_cnt_inc  = 1'b1;
                w_pend_clr = 1'b1;
              end else begin
                w_set_ovf  = 1'b1;
              end
            end
          end else if (w_room) begin
            mem_we     = 1'b1;
            mem_din    = w_char;
            w_addr_inc = 1'b1;
            w_pend_set = 1'b1;
          end else begin
            w_set_ovf = 1'b1;
          end
        end
      end
      TERM1: begin
        mem_we      = 1'b1;
        w_addr_inc  = 1'b1;
        w_cnt_inc   = 1'b1;
        w_pend_clr  = 1'b1;
        w_state_nxt = TERM2;
      end
      TERM2: begin
        mem_we      = 1'b1;
        w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_clear) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_addr_inc) r_addr  <= r_addr + ADDR_WIDTH'(1);
      if (w_cnt_inc)  r_count <= r_count + ADDR_WIDTH'(1);
      if (w_set_ovf)  r_ovf   <= 1'b1;
      if (w_pend_set)      r_pending <= 1'b1;
      else if (w_pend_clr) r_pending <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_word_loader.sv
// ============================================================================
// tb_word_loader : directed stimulus with a write scoreboard checked by a monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_word_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [3:0] word_count;
  logic       overflow;
  logic       done;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  word_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .word_count(word_count),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {28'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {28'd0, mem_addr}, {28'd0, e.addr});
        check("write_data", {24'd0, mem_din}, {24'd0, e.data});
      end
    end
  end

  task automatic expect_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = a[3:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start();
    @(posedge clk); #1 cs = 1'b1;
    @(posedge clk); #1 cs = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = c;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("send_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic finish_run(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done"}, {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    check({name, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Stream offered while idle must not be consumed.
    in_valid = 1'b1; in_data = 8'h61;
    repeat (3) @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    check("idle_mem_addr", {28'd0, mem_addr}, 32'd0);
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h00;

    // "ab cd"
    expect_wr(0, "a"); expect_wr(1, "b"); expect_wr(2, 8'h00);
    expect_wr(3, "c"); expect_wr(4, "d"); expect_wr(5, 8'h00); expect_wr(6, 8'h00);
    start();
    send_str("ab cd"); send(8'h00);
    finish_run("t_abcd");
    check("t_abcd_count", {28'd0, word_count}, 32'd2);
    check("t_abcd_ovf", {31'd0, overflow}, 32'd0);
    check("t_abcd_addr", {28'd0, mem_addr}, 32'd6);
    in_valid = 1'b1; in_data = 8'h7A;
    repeat (3) @(negedge clk);
    check("done_hold_addr", {28'd0, mem_addr}, 32'd6);
    check("done_hold_flag", {31'd0, done}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h00;

    // "  ab  " with cs pulsed mid-run (must be ignored)
    expect_wr(0, "a"); expect_wr(1, "b"); expect_wr(2, 8'h00); expect_wr(3, 8'h00);
    start();
    send_str("  a");
    cs = 1'b1;
    send_str("b  ");
    cs = 1'b0;
    send(8'h00);
    finish_run("t_spaces");
    check("t_spaces_count", {28'd0, word_count}, 32'd1);

    // empty message
    expect_wr(0, 8'h00);
    start();
    send(8'h00);
    finish_run("t_empty");
    check("t_empty_count", {28'd0, word_count}, 32'd0);
    check("t_empty_addr", {28'd0, mem_addr}, 32'd0);

    // 20-char word overflows a 16-entry memory
    for (int i = 0; i < 14; i++) expect_wr(i, 8'h61 + i[7:0]);
    expect_wr(14, 8'h00); expect_wr(15, 8'h00);
    start();
    for (int i = 0; i < 20; i++) send(8'h61 + i[7:0]);
    send(8'h00);
    finish_run("t_ovf");
    check("t_ovf_flag", {31'd0, overflow}, 32'd1);
    check("t_ovf_count", {28'd0, word_count}, 32'd1);
    check("t_ovf_addr", {28'd0, mem_addr}, 32'd15);

    // async reset in the middle of a load
    expect_wr(0, "a"); expect_wr(1, "b"); expect_wr(2, "c");
    start();
    send_str("abc");
    check("mid_pre_addr", {28'd0, mem_addr}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_addr", {28'd0, mem_addr}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_din", {24'd0, mem_din}, 32'd0);
    check("mid_rst_pending_writes", exp_q.size(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_wr(0, "x"); expect_wr(1, 8'h00); expect_wr(2, 8'h00);
    start();
    send("x"); send(8'h00);
    finish_run("t_restart");
    check("t_restart_count", {28'd0, word_count}, 32'd1);

    // case folding option
`ifdef WORD_LOADER_LOWERCASE_EN
    expect_wr(0, 8'h61); expect_wr(1, 8'h62); expect_wr(2, 8'h63);
`else
    expect_wr(0, 8'h41); expect_wr(1, 8'h62); expect_wr(2, 8'h43);
`endif
    expect_wr(3, 8'h00); expect_wr(4, 8'h00);
    start();
    send_str("AbC"); send(8'h00);
    finish_run("t_case");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
